// File: rtl/ahb_wdata_drain_pkg.sv
// Shared definitions for the AHB-side write-data drain of the AXI-to-AHB bridge.
package ahb_wdata_drain_pkg;

  localparam int unsigned DataW = 64;
  localparam int unsigned AhbDw = 32;
  localparam int unsigned LenW  = 8;

  localparam logic LaneLo = 1'b0;
  localparam logic LaneHi = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrive
  } drain_state_e;

endpackage

// File: rtl/ahb_wdata_drain_if.sv
// Command, FIFO read-port and HWDATA beat signals of the write-data drain.
interface ahb_wdata_drain_if;
  import ahb_wdata_drain_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LenW-1:0]  cmd_len;
  logic             cmd_lane;
  logic             fifo_empty;
  logic             fifo_read_en;
  logic [DataW-1:0] fifo_data;
  logic [AhbDw-1:0] hwdata;
  logic             beat_valid;
  logic             beat_ready;
  logic             beat_last;
  logic             burst_done;
  logic             abort;

  modport master (
    output cmd_valid, cmd_len, cmd_lane, fifo_empty, fifo_data, beat_ready, abort,
    input  cmd_ready, fifo_read_en, hwdata, beat_valid, beat_last, burst_done
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_lane, fifo_empty, fifo_data, beat_ready, abort,
    output cmd_ready, fifo_read_en, hwdata, beat_valid, beat_last, burst_done
  );

endinterface

// File: rtl/ahb_wdata_drain.sv
// Pops 64-bit write words from the FIFO and splits them into a burst of 32-bit HWDATA beats.
module ahb_wdata_drain
  import ahb_wdata_drain_pkg::*;
(
  input logic              rclk_i,
  input logic              resetn_i,
  ahb_wdata_drain_if.slave bus_io
);

  drain_state_e     state_q, state_d;
  logic [DataW-1:0] hold_q, hold_d;
  logic             lane_q, lane_d;
  logic [LenW-1:0]  remaining_q, remaining_d;

  always_ff @(posedge rclk_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      lane_q      <= LaneLo;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    hold_d             = hold_q;
    lane_d             = lane_q;
    remaining_d        = remaining_q;
    bus_io.cmd_ready    = 1'b0;
    bus_io.fifo_read_en = 1'b0;
    bus_io.beat_valid   = 1'b0;
    bus_io.beat_last    = 1'b0;
    bus_io.burst_done   = 1'b0;
    bus_io.hwdata       = (lane_q == LaneHi) ? hold_q[DataW-1:AhbDw] : hold_q[AhbDw-1:0];

    unique case (state_q)
      StIdle: begin
        // Abort blocks acceptance so a command is never both handshaken and dropped.
        bus_io.cmd_ready = !bus_io.abort;
        if (bus_io.cmd_valid && !bus_io.abort) begin
          remaining_d = bus_io.cmd_len;
          lane_d      = bus_io.cmd_lane;
          state_d     = StFetch;
        end
      end

      StFetch: begin
        if (bus_io.abort) begin
          state_d = StIdle;
        end else if (!bus_io.fifo_empty) begin
          bus_io.fifo_read_en = 1'b1;
          hold_d              = bus_io.fifo_data;
          state_d             = StDrive;
        end
      end

      StDrive: begin
        bus_io.beat_valid = 1'b1;
        bus_io.beat_last  = (remaining_q == '0);
        if (bus_io.abort) begin
          state_d = StIdle;
        end else if (bus_io.beat_ready) begin
          if (remaining_q == '0) begin
            bus_io.burst_done = 1'b1;
            state_d           = StIdle;
          end else begin
            remaining_d = remaining_q - LenW'(1);
            lane_d      = ~lane_q;
            // Upper half consumed: refill in the same cycle to avoid a bubble.
            if (lane_q == LaneHi) begin
              if (!bus_io.fifo_empty) begin
                bus_io.fifo_read_en = 1'b1;
                hold_d              = bus_io.fifo_data;
              end else begin
                state_d = StFetch;
              end
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ahb_wdata_drain.sv
// Scoreboard bench for ahb_wdata_drain with a queue-based FIFO model.
module tb_ahb_wdata_drain;
  import ahb_wdata_drain_pkg::*;

  typedef struct {
    logic [AhbDw-1:0] data;
    logic             last;
  } beat_t;

  logic clk;
  logic rst_n;

  ahb_wdata_drain_if bus();

  ahb_wdata_drain dut (
    .rclk_i  (clk),
    .resetn_i(rst_n),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t            sb[$];
  logic [DataW-1:0] fifo_m[$];
  logic [DataW-1:0] pend[$];
  int               beat_cyc[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int beats, pops, mode, accept_cyc;
  bit done_seen;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fifo_m.size() == 0);
    bus.fifo_data  = (fifo_m.size() == 0) ? '0 : fifo_m[0];
  endtask

  // Sample on the falling edge, then advance the FIFO model after the rising edge.
  task automatic tick();
    bit pop, acc;
    @(negedge clk);
    pop = bus.fifo_read_en;
    acc = bus.beat_valid && bus.beat_ready && !bus.abort;
    if (pop) check("pop_empty", bus.fifo_empty, 0);
    if (bus.beat_valid && !bus.beat_ready) check("stall_pop", pop, 0);
    if (bus.beat_valid && sb.size() > 0) begin
      check("hwdata", bus.hwdata, sb[0].data);
      check("beat_last", bus.beat_last, sb[0].last);
    end
    if (acc) begin
      if (sb.size() == 0) begin
        check("extra_beat", bus.beat_valid, 0);
      end else begin
        check("burst_done", bus.burst_done, sb[0].last);
        if (sb[0].last) done_seen = 1;
        void'(sb.pop_front());
        beats++;
        beat_cyc.push_back(cyc);
      end
    end else begin
      check("done_idle", bus.burst_done, 0);
    end
    if (pop) pops++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
    refresh();
  endtask

  task automatic run_burst(input int len, input bit lane, input logic [63:0] words[$],
                           input int n_now, input int budget);
    bit l;
    int w, n, wait_cnt, stall_cnt;
    bit ab_fired;
    l = lane;
    w = 0;
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.data = l ? words[w][63:32] : words[w][31:0];
      b.last = (i == len);
      sb.push_back(b);
      if (l) w++;
      l = ~l;
    end
    pend.delete();
    for (int i = 0; i < words.size(); i++) begin
      if (i < n_now) fifo_m.push_back(words[i]);
      else pend.push_back(words[i]);
    end
    refresh();
    beats = 0;
    pops = 0;
    done_seen = 0;
    beat_cyc.delete();
    wait_cnt = 0;
    stall_cnt = 0;
    ab_fired = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LenW'(len);
    bus.cmd_lane  = lane;
    #2;
    check("cmd_ready_accept", bus.cmd_ready, 1);
    accept_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!done_seen && !ab_fired && n < budget) begin
      case (mode)
        2: begin
          bus.beat_ready = !(beats == 1 && stall_cnt < 4);
          if (!bus.beat_ready) stall_cnt++;
        end
        3: begin
          bus.abort = (beats == 2);
          if (bus.abort) ab_fired = 1;
        end
        4: bus.beat_ready = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
      tick();
      n++;
      if (mode == 1 && beats >= 2 && pend.size() > 0) begin
        wait_cnt++;
        if (wait_cnt == 5) begin
          while (pend.size() > 0) fifo_m.push_back(pend.pop_front());
          refresh();
        end
      end
    end
    bus.abort = 1'b0;
    bus.beat_ready = 1'b1;
    if (mode != 3) check("timeout", done_seen, 1);
    #2;
    check("cmd_ready_after", bus.cmd_ready, 1);
    check("valid_after", bus.beat_valid, 0);
  endtask

  initial begin
    logic [63:0] wq[$];
    bus.cmd_valid  = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_lane   = 1'b0;
    bus.beat_ready = 1'b1;
    bus.abort      = 1'b0;
    refresh();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_read_en", bus.fifo_read_en, 0);
    check("rst_valid", bus.beat_valid, 0);
    check("rst_last", bus.beat_last, 0);
    check("rst_done", bus.burst_done, 0);
    check("rst_hwdata", bus.hwdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two words, lane 0, full throughput.
    mode = 0;
    wq = '{64'h11112222_33334444, 64'h55556666_77778888};
    run_burst(3, 1'b0, wq, 2, 50);
    check("t1_pops", pops, 2);
    check("t1_latency", beat_cyc[0] - accept_cyc, 2);
    check("t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);

    // Single beat from the upper lane.
    wq = '{64'hAAAABBBB_CCCCDDDD};
    run_burst(0, 1'b1, wq, 1, 50);
    check("t2_pops", pops, 1);
    check("t2_beats", beats, 1);

    // Second word arrives late.
    mode = 1;
    wq = '{64'h11112222_33334444, 64'h55556666_77778888};
    run_burst(3, 1'b0, wq, 1, 50);
    check("t3_pops", pops, 2);
    check("t3_gap_ge5", (beat_cyc[2] - beat_cyc[1] - 1) >= 5, 1);

    // Consumer stalls on beat 2.
    mode = 2;
    run_burst(3, 1'b0, wq, 2, 50);
    check("t4_pops", pops, 2);
    check("t4_stall_len", beat_cyc[1] - beat_cyc[0], 5);

    // Abort on beat 3 of an 8-beat burst.
    mode = 3;
    wq = '{64'h01010101_02020202, 64'h03030303_04040404,
           64'h05050505_06060606, 64'h07070707_08080808};
    run_burst(7, 1'b0, wq, 4, 50);
    check("t5_pops", pops, 2);
    check("t5_beats", beats, 2);
    sb.delete();
    fifo_m.delete();
    refresh();
    tick();
    check("t5_idle_read_en", bus.fifo_read_en, 0);

    // Maximum length from the upper lane with random back-pressure.
    mode = 4;
    wq.delete();
    for (int i = 0; i < 129; i++) wq.push_back({$urandom, $urandom});
    run_burst(255, 1'b1, wq, 129, 3000);
    check("t6_beats", beats, 256);
    check("t6_pops", pops, 129);
    check("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
